// File: rtl/ace_loader_pkg.sv
// Shared types and default constants for the ACE RLE snapshot loader.
package ace_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LIT,
        CNT,
        DAT,
        RUN,
        HOLD
    } loader_state_e;

    localparam logic [15:0] DEF_BASE_ADDR = 16'h2000;
    localparam logic [7:0]  DEF_ESC_BYTE  = 8'hED;
    localparam int unsigned DEF_TIMEOUT   = 3000000;

endpackage

// File: rtl/ace_rle_loader.sv
// Streams an ioctl download into memory, expanding ESC/count/data runs,
// with write backpressure, end-marker hold and address overflow detection.
module ace_rle_loader
    import ace_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [7:0]        ESC_BYTE  = DEF_ESC_BYTE,
    parameter int                RUN_W     = 8,
    parameter int unsigned       TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    input  logic              raw_mode,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic              loader_en,
    output logic              loader_reset,
    output logic              done,
    output logic              overflow
);

    loader_state_e     state_q;
    logic              dl_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic              mem_wr_q;
    logic              wait_q;
    logic              loader_en_q;
    logic              loader_reset_q;
    logic              done_q;
    logic              overflow_q;
    logic              ending_q;
    logic [RUN_W-1:0]  count_q;
    logic [31:0]       timer_q;

    logic dl_rise;
    logic dl_fall;
    logic start;
    logic accept;
    logic slot_free;
    logic ovf_now;

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign start     = dl_rise & (ioctl_index != 8'd0);
    assign accept    = mem_wr_q & mem_ready;
    // The write slot can take a new byte when empty or emptying this cycle.
    assign slot_free = ~mem_wr_q | mem_ready;
    assign ovf_now   = overflow_q | (accept & (&mem_addr_q));

    // NOTE: every register here is state, so all updates are non-blocking;
    // later assignments in the same cycle deliberately override earlier ones.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            dl_q           <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_data_q     <= 8'h00;
            mem_wr_q       <= 1'b0;
            wait_q         <= 1'b0;
            loader_en_q    <= 1'b0;
            loader_reset_q <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            ending_q       <= 1'b0;
            count_q        <= '0;
            timer_q        <= 32'd0;
        end else begin
            dl_q           <= ioctl_download;
            loader_reset_q <= 1'b0;

            if (accept) begin
                mem_wr_q   <= 1'b0;
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                if (&mem_addr_q) begin
                    overflow_q <= 1'b1;
                end
            end

            if (start) begin
                state_q        <= LIT;
                loader_reset_q <= 1'b1;
                mem_addr_q     <= BASE_ADDR;
                mem_wr_q       <= 1'b0;
                wait_q         <= 1'b0;
                loader_en_q    <= 1'b0;
                done_q         <= 1'b0;
                overflow_q     <= 1'b0;
                ending_q       <= 1'b0;
                count_q        <= '0;
                timer_q        <= 32'd0;
            end else if ((dl_fall || ending_q) && (loader_en_q || state_q != IDLE)) begin
                // Let an in-flight write land before releasing the bus.
                ending_q <= 1'b1;
                if (slot_free) begin
                    state_q     <= IDLE;
                    wait_q      <= 1'b0;
                    loader_en_q <= 1'b0;
                    done_q      <= 1'b1;
                    ending_q    <= 1'b0;
                end
            end else begin
                if (ioctl_wr && state_q != IDLE) begin
                    loader_en_q <= 1'b1;
                end

                case (state_q)
                    IDLE: ;
                    LIT: begin
                        if (ioctl_wr && slot_free) begin
                            if (ioctl_dout != ESC_BYTE || raw_mode) begin
                                mem_wr_q   <= ~ovf_now;
                                mem_data_q <= ioctl_dout;
                                wait_q     <= ~ovf_now;
                            end else begin
                                state_q <= CNT;
                                wait_q  <= 1'b0;
                            end
                        end else if (slot_free) begin
                            wait_q <= 1'b0;
                        end
                    end
                    CNT: begin
                        if (ioctl_wr) begin
                            if (ioctl_dout != 8'h00) begin
                                count_q <= RUN_W'(ioctl_dout);
                                state_q <= DAT;
                            end else begin
                                timer_q <= 32'd0;
                                wait_q  <= 1'b1;
                                state_q <= HOLD;
                            end
                        end
                    end
                    DAT: begin
                        if (ioctl_wr) begin
                            mem_data_q <= ioctl_dout;
                            wait_q     <= 1'b1;
                            state_q    <= RUN;
                        end
                    end
                    RUN: begin
                        if (slot_free) begin
                            if (count_q != '0) begin
                                mem_wr_q <= ~ovf_now;
                                count_q  <= count_q - RUN_W'(1);
                            end else begin
                                wait_q  <= 1'b0;
                                state_q <= LIT;
                            end
                        end
                    end
                    HOLD: begin
                        if (timer_q + 32'd1 >= TIMEOUT) begin
                            wait_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q + 32'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_wait   = wait_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_wr       = mem_wr_q;
    assign loader_en    = loader_en_q;
    assign loader_reset = loader_reset_q;
    assign done         = done_q;
    assign overflow     = overflow_q;

endmodule
